conv_window_gen: RTL
====================

// Module: conv_window_gen
// PURPOSE
//  Downstream consumer of the convolution line-buffer FIFO. Takes a raster pixel stream
//  (row-major, row_len x col_len), keeps two row line buffers plus a 3x3 shift window,
//  and emits strided 3x3 windows with a valid/ready handshake to the MAC array.
//  Frame geometry and stride are latched on start; frame_done marks the last window.
// PARAMETERS
//  DATA_W       8   pixel width in bits
//  MAX_ROW_LEN  32  line-buffer depth; row_len must be <= this value
// PORTS
//  clk        in   1          clock
//  rst        in   1          synchronous reset, active-high
//  start      in   1          1-cycle pulse: latch config and begin frame (ignored unless IDLE)
//  row_len    in   5          pixels per row, legal 3..MAX_ROW_LEN
//  col_len    in   5          rows per frame, legal 3..31
//  stride     in   3          1 or 2; any other value is treated as 1
//  in_valid   in   1          input pixel valid
//  in_data    in   DATA_W     input pixel
//  in_ready   out  1          pixel accepted when in_valid & in_ready
//  win_valid  out  1          window valid
//  win_ready  in   1          window consumed when win_valid & win_ready
//  win_data   out  9*DATA_W   [(3*i+j)*DATA_W +: DATA_W] = window row i (0=top), col j (0=left)
//  win_row    out  5          output-map row index of the current window
//  win_col    out  5          output-map column index of the current window
//  frame_done out  1          1-cycle pulse after the final window handshake
//  busy       out  1          high in RUN
//  cfg_err    out  1          1-cycle pulse: start with row_len<3, col_len<3 or row_len>MAX_ROW_LEN
// BEHAVIOUR
//  Reset: state IDLE; in_ready, win_valid, frame_done, busy, cfg_err = 0; win_data,
//   win_row, win_col = 0; pixel/output counters = 0. Line-buffer RAM not cleared.
//  FSM: IDLE -start&cfg ok-> RUN; IDLE -start&cfg bad-> IDLE + cfg_err.
//   RUN -last window handshaken-> DONE; DONE -> IDLE (frame_done=1 in DONE, 1 cycle).
//   Pixels after the last window-producing pixel (if any) are still accepted until the
//   input pixel counter reaches row_len*col_len; DONE waits for both conditions.
//  Mid-frame rst: back to IDLE next edge, all outputs to reset values, partial frame lost.
//  start while busy: ignored. Config inputs sampled only on accepted start.
//  in_ready = (state==RUN) & pixels_remaining & (!win_valid | win_ready).
//  On accept of pixel (r,c): top=lb1[c], mid=lb0[c]; lb1[c]<=lb0[c]; lb0[c]<=in_data;
//   window columns shift left, new column {top,mid,in_data} enters at j=2; c wraps to 0
//   at row_len-1 and r increments.
//  Window emit: on accept of (r,c) with r>=2, c>=2, (r-2)%s==0, (c-2)%s==0 (s=1|2):
//   next cycle win_valid=1, win_data = pixels rows r-2..r, cols c-2..c,
//   win_row=(r-2)/s, win_col=(c-2)/s. Latency 1 cycle from pixel accept.
//  win_valid held with win_data/win_row/win_col stable until win_ready; simultaneous
//   win_ready and new accepted emitting pixel: new window replaces old, win_valid stays 1.
//  Output geometry: out_cols=floor((row_len-3)/s)+1, out_rows=floor((col_len-3)/s)+1;
//   trailing columns/rows not covered by a full stride are consumed and discarded.
//  Counters: r,c 5-bit; counter arithmetic in 6 bits, no wrap within legal config.
// TESTING
//  1 5x5, s=1, pixel=r*5+c, win_ready=1 -> 9 windows; first {0,1,2,5,6,7,10,11,12},
//    last {12,13,14,17,18,19,22,23,24}; frame_done once after 9th, 25 pixels accepted.
//  2 5x5, s=2 -> 4 windows, top-left pixels 0,2,10,12; win_row/win_col (0,0)(0,1)(1,0)(1,1).
//  3 6x6, s=2 -> out 2x2 (floor); column 5 and row 5 consumed, no window emitted from them.
//  4 backpressure: win_ready=0 for 10 cycles on window 3 -> in_ready=0, win_data stable,
//    no pixel lost; sequence identical to test 1.
//  5 start with row_len=2 -> cfg_err 1 cycle, busy=0, in_ready=0; stride=3 on 5x5 -> as test 1.
//  6 rst after 12 pixels -> next cycle all outputs 0, state IDLE; new start replays test 1 exactly.

Source files
------------

// File: rtl/conv_window_gen_if.sv
// Pixel-in / window-out handshake bundle for conv_window_gen.
// The slave modport is the window generator; the master modport is the pixel source and window consumer.
interface conv_window_gen_if #(
  parameter int DATA_W = 8
);
  logic                  in_valid;
  logic [DATA_W-1:0]     in_data;
  logic                  in_ready;
  logic                  win_valid;
  logic                  win_ready;
  logic [9*DATA_W-1:0]   win_data;
  logic [4:0]            win_row;
  logic [4:0]            win_col;

  modport master (
    output in_valid, in_data, win_ready,
    input  in_ready, win_valid, win_data, win_row, win_col
  );

  modport slave (
    input  in_valid, in_data, win_ready,
    output in_ready, win_valid, win_data, win_row, win_col
  );
endinterface

// File: rtl/conv_window_gen.sv
// Strided 3x3 window generator over a raster pixel stream.
// Two row line buffers plus a 3x3 shift window feed a valid/ready window output.
module conv_window_gen #(
  parameter int DATA_W      = 8,
  parameter int MAX_ROW_LEN = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [4:0]            row_len,
  input  logic [4:0]            col_len,
  input  logic [2:0]            stride,
  conv_window_gen_if.slave      bus,
  output logic                  frame_done,
  output logic                  busy,
  output logic                  cfg_err
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [4:0]            row_len_q, row_len_d;
  logic [4:0]            col_len_q, col_len_d;
  logic                  s2_q, s2_d;
  logic [4:0]            r_q, r_d;
  logic [4:0]            c_q, c_d;
  logic [9*DATA_W-1:0]   win_q, win_d;
  logic                  win_valid_q, win_valid_d;
  logic [4:0]            win_row_q, win_row_d;
  logic [4:0]            win_col_q, win_col_d;
  logic                  busy_q, busy_d;
  logic                  frame_done_q, frame_done_d;
  logic                  cfg_err_q, cfg_err_d;

  // Line buffers: lb0 holds the previous row, lb1 the row before that. Not reset.
  logic [DATA_W-1:0]     lb0_mem [MAX_ROW_LEN];
  logic [DATA_W-1:0]     lb1_mem [MAX_ROW_LEN];

  logic [DATA_W-1:0]     new_col_s [3];
  logic                  cfg_ok_s;
  logic                  start_ok_s;
  logic                  pix_left_s;
  logic                  out_free_s;
  logic                  accept_s;
  logic                  emit_s;
  logic                  last_col_s;
  logic [5:0]            r_m2_s;
  logic [5:0]            c_m2_s;

  assign cfg_ok_s   = (row_len >= 5'd3) && (col_len >= 5'd3) &&
                      ({1'b0, row_len} <= 6'(MAX_ROW_LEN));
  assign start_ok_s = (state_q == ST_IDLE) && start && cfg_ok_s;
  assign pix_left_s = ({1'b0, r_q} < {1'b0, col_len_q});
  assign out_free_s = !win_valid_q || bus.win_ready;
  assign accept_s   = (state_q == ST_RUN) && pix_left_s && out_free_s && bus.in_valid;
  assign last_col_s = ({1'b0, c_q} == ({1'b0, row_len_q} - 6'd1));
  assign r_m2_s     = {1'b0, r_q} - 6'd2;
  assign c_m2_s     = {1'b0, c_q} - 6'd2;
  // With stride 2, (x-2) is even exactly when x is even.
  assign emit_s     = accept_s && (r_q >= 5'd2) && (c_q >= 5'd2) &&
                      (!s2_q || (!r_q[0] && !c_q[0]));

  assign new_col_s[0] = lb1_mem[c_q];
  assign new_col_s[1] = lb0_mem[c_q];
  assign new_col_s[2] = bus.in_data;

  assign bus.in_ready  = (state_q == ST_RUN) && pix_left_s && out_free_s;
  assign bus.win_valid = win_valid_q;
  assign bus.win_data  = win_q;
  assign bus.win_row   = win_row_q;
  assign bus.win_col   = win_col_q;
  assign frame_done    = frame_done_q;
  assign busy          = busy_q;
  assign cfg_err       = cfg_err_q;

  // Frame sequencing: config latch, state transitions and status pulses.
  always_comb begin
    state_d      = state_q;
    row_len_d    = row_len_q;
    col_len_d    = col_len_q;
    s2_d         = s2_q;
    cfg_err_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start && cfg_ok_s) begin
          state_d   = ST_RUN;
          row_len_d = row_len;
          col_len_d = col_len;
          s2_d      = (stride == 3'd2);
        end else if (start) begin
          cfg_err_d = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        // All pixels taken and no window left waiting (or it is leaving now).
        if (!pix_left_s && out_free_s) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    busy_d       = (state_d == ST_RUN);
    frame_done_d = (state_d == ST_DONE);
  end

  // Pixel position, 3x3 shift window and output window registers.
  always_comb begin
    r_d         = r_q;
    c_d         = c_q;
    win_d       = win_q;
    win_valid_d = win_valid_q;
    win_row_d   = win_row_q;
    win_col_d   = win_col_q;
    if (start_ok_s) begin
      r_d         = 5'd0;
      c_d         = 5'd0;
      win_valid_d = 1'b0;
    end else if (accept_s) begin
      for (int i = 0; i < 3; i++) begin
        win_d[(3*i+0)*DATA_W +: DATA_W] = win_q[(3*i+1)*DATA_W +: DATA_W];
        win_d[(3*i+1)*DATA_W +: DATA_W] = win_q[(3*i+2)*DATA_W +: DATA_W];
        win_d[(3*i+2)*DATA_W +: DATA_W] = new_col_s[i];
      end
      if (last_col_s) begin
        c_d = 5'd0;
        r_d = r_q + 5'd1;
      end else begin
        c_d = c_q + 5'd1;
      end
      if (emit_s) begin
        win_valid_d = 1'b1;
        win_row_d   = s2_q ? r_m2_s[5:1] : r_m2_s[4:0];
        win_col_d   = s2_q ? c_m2_s[5:1] : c_m2_s[4:0];
      end else if (bus.win_ready) begin
        win_valid_d = 1'b0;
      end else begin
        win_valid_d = win_valid_q;
      end
    end else if (bus.win_ready) begin
      win_valid_d = 1'b0;
    end else begin
      win_valid_d = win_valid_q;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      row_len_q    <= 5'd0;
      col_len_q    <= 5'd0;
      s2_q         <= 1'b0;
      r_q          <= 5'd0;
      c_q          <= 5'd0;
      win_q        <= '0;
      win_valid_q  <= 1'b0;
      win_row_q    <= 5'd0;
      win_col_q    <= 5'd0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      cfg_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      row_len_q    <= row_len_d;
      col_len_q    <= col_len_d;
      s2_q         <= s2_d;
      r_q          <= r_d;
      c_q          <= c_d;
      win_q        <= win_d;
      win_valid_q  <= win_valid_d;
      win_row_q    <= win_row_d;
      win_col_q    <= win_col_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
      cfg_err_q    <= cfg_err_d;
    end
  end

  // Line-buffer write: the older row moves up, the incoming pixel replaces it.
  always_ff @(posedge clk) begin
    if (accept_s) begin
      lb1_mem[c_q] <= lb0_mem[c_q];
      lb0_mem[c_q] <= bus.in_data;
    end
  end

endmodule
